bound_flasher_monitor: RTL and testbench

- Passive checker on the 16-bit LED bar driven by the bound flasher.
- Decodes the thermometer pattern back to a level and tracks the flash sequence phase.
- Flags malformed patterns, illegal steps and illegal reversals, including the flick-driven kickbacks.
- Sits beside the flasher in the top-level and bench, and feeds error/cycle counters to the status logic.

---
 rtl/bound_flasher_monitor.sv | 155 +++++++++++++++
 tb/tb_bound_flasher_monitor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_monitor.sv
// Passive checker for the bound flasher LED bar: decodes the thermometer
// level, tracks the flash sequence phase and counts completions and errors.
module bound_flasher_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      led,
    output logic [4:0]       level,
    output logic [2:0]       phase,
    output logic             fall3,
    output logic             cycle_done,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        RESYNC, IDLE, RISE1, FALL1, RISE2, FALL2, RISE3, PH7
    } phase_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    phase_t      st;
    phase_t      nst;
    logic [15:0] led_q;
    logic [4:0]  l_new;
    logic        legal;
    logic        up;
    logic        dn;
    logic        nf3;
    logic        err;
    logic        done;
    logic [1:0]  code;

    // A legal bar is 2^L-1: adding one clears every lit bit.
    always_comb begin
        l_new = '0;
        for (int i = 0; i < 16; i++) l_new = l_new + {4'b0, led_q[i]};
        legal = (led_q & (led_q + 16'd1)) == 16'd0;
        up    = l_new == level + 5'd1;
        dn    = (level != 5'd0) && (l_new == level - 5'd1);
    end

    always_comb begin
        nst  = st;
        nf3  = fall3;
        err  = 1'b0;
        code = 2'b00;
        done = 1'b0;
        if (st == RESYNC) begin
            if (legal && l_new == 5'd0) nst = IDLE;
        end else if (!legal) begin
            err  = 1'b1;
            code = 2'b01;
        end else if (st == IDLE) begin
            if (l_new == 5'd1) begin
                nst = RISE1;
            end else if (l_new != 5'd0) begin
                err  = 1'b1;
                code = 2'b10;
            end
        end else if (!up && !dn) begin
            err  = 1'b1;
            code = 2'b10;
        end else begin
            code = 2'b11;
            case (st)
                RISE1: begin
                    if (up) err = l_new == 5'd7;
                    else if (level == 5'd6) nst = FALL1;
                    else err = 1'b1;
                end
                FALL1: begin
                    if (up) begin
                        if (level == 5'd0) nst = RISE2;
                        else err = 1'b1;
                    end
                end
                RISE2: begin
                    if (up) err = l_new == 5'd12;
                    else if (level == 5'd6) nst = FALL1;
                    else if (level == 5'd11) nst = FALL2;
                    else err = 1'b1;
                end
                FALL2: begin
                    if (up) begin
                        if (level == 5'd5) nst = RISE3;
                        else err = 1'b1;
                    end else if (level == 5'd5) begin
                        nst = FALL1;
                    end
                end
                RISE3: begin
                    if (dn) begin
                        if (level == 5'd6 || level == 5'd11) begin
                            nst = PH7;
                            nf3 = 1'b0;
                        end else if (level == 5'd16) begin
                            nst = PH7;
                            nf3 = 1'b1;
                        end else begin
                            err = 1'b1;
                        end
                    end
                end
                PH7: begin
                    if (fall3) begin
                        if (up) begin
                            err = 1'b1;
                        end else if (l_new == 5'd0) begin
                            nst  = IDLE;
                            done = 1'b1;
                        end
                    end else if (up) begin
                        if (level == 5'd5) nst = RISE3;
                        else err = 1'b1;
                    end else begin
                        err = l_new == 5'd4;
                    end
                end
                default: nst = RESYNC;
            endcase
        end
        if (err) nst = RESYNC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q      <= '0;
            st         <= RESYNC;
            level      <= '0;
            fall3      <= 1'b0;
            cycle_done <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= 2'b00;
            cycle_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            led_q      <= led;
            st         <= nst;
            fall3      <= (nst == PH7) ? nf3 : 1'b0;
            cycle_done <= done;
            err_pulse  <= err;
            if (legal) level <= l_new;
            if (err) err_code <= code;
            if (done && cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
            if (err && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end

    assign phase = st;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Self-checking bench for bound_flasher_monitor: segment tables drive level
// ramps, expected outputs flow through a latency-tagged scoreboard queue.
module tb_bound_flasher_monitor;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [15:0]      led;
    logic [4:0]       level;
    logic [2:0]       phase;
    logic             fall3;
    logic             cycle_done;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] err_cnt;

    bound_flasher_monitor #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .led(led), .level(level), .phase(phase),
        .fall3(fall3), .cycle_done(cycle_done), .err_pulse(err_pulse),
        .err_code(err_code), .cycle_cnt(cycle_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] lvl;
        logic [2:0] ph;
        logic       f3;
        logic       ep;
        logic [1:0] code;
        logic       done;
        int         due;
    } exp_t;

    typedef struct {
        int         target;
        logic [2:0] ph;
        logic       f3;
        logic [2:0] last_ph;
        logic       last_f3;
        logic       done;
    } seg_t;

    exp_t q[$];
    seg_t segs[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_lvl = 0;
    logic [1:0] cur_code = 2'b00;
    int   exp_cycles = 0;
    int   exp_errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] thermo(int l);
        logic [16:0] t;
        t = (17'd1 << l) - 17'd1;
        return t[15:0];
    endfunction

    function automatic seg_t mk(int t, logic [2:0] p, logic f);
        seg_t s;
        s.target = t; s.ph = p; s.f3 = f;
        s.last_ph = p; s.last_f3 = f; s.done = 1'b0;
        return s;
    endfunction

    function automatic seg_t fin();
        seg_t s;
        s.target = 0; s.ph = 3'd7; s.f3 = 1'b1;
        s.last_ph = 3'd1; s.last_f3 = 1'b0; s.done = 1'b1;
        return s;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_due();
        while (q.size() != 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("out@%0d", e.due),
                  {19'd0, level, phase, fall3, err_pulse, err_code, cycle_done},
                  {19'd0, e.lvl, e.ph, e.f3, e.ep, e.code, e.done});
        end
    endtask

    task automatic drive(logic [15:0] v, int l, logic [2:0] p, logic f,
                         logic ep, logic d);
        exp_t e;
        @(negedge clk);
        check_due();
        led = v;
        e.lvl = l[4:0]; e.ph = p; e.f3 = f; e.ep = ep;
        e.code = cur_code; e.done = d; e.due = cyc + 2;
        q.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            check_due();
        end
    endtask

    task automatic ramp(seg_t s);
        logic last;
        while (cur_lvl != s.target) begin
            cur_lvl = (cur_lvl < s.target) ? cur_lvl + 1 : cur_lvl - 1;
            last = cur_lvl == s.target;
            drive(thermo(cur_lvl), cur_lvl, last ? s.last_ph : s.ph,
                  last ? s.last_f3 : s.f3, 1'b0, last & s.done);
        end
        if (s.done) exp_cycles++;
    endtask

    task automatic err_step(logic [15:0] v, int l, logic [1:0] c);
        cur_code = c;
        cur_lvl = l;
        exp_errs++;
        drive(v, l, 3'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic back_to_idle();
        cur_lvl = 0;
        drive(16'h0000, 0, 3'd1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        led = 16'h0000;
        // run 1: plain sequence
        segs.push_back(mk(6, 3'd2, 0)); segs.push_back(mk(0, 3'd3, 0));
        segs.push_back(mk(11, 3'd4, 0)); segs.push_back(mk(5, 3'd5, 0));
        segs.push_back(mk(16, 3'd6, 0)); segs.push_back(fin());
        // run 2: kickback at 6 in RISE2
        segs.push_back(mk(6, 3'd2, 0)); segs.push_back(mk(0, 3'd3, 0));
        segs.push_back(mk(6, 3'd4, 0)); segs.push_back(mk(0, 3'd3, 0));
        segs.push_back(mk(11, 3'd4, 0)); segs.push_back(mk(5, 3'd5, 0));
        segs.push_back(mk(16, 3'd6, 0)); segs.push_back(fin());
        // run 3: kickback at 11 in RISE2 resolved through FALL1
        segs.push_back(mk(6, 3'd2, 0)); segs.push_back(mk(0, 3'd3, 0));
        segs.push_back(mk(11, 3'd4, 0)); segs.push_back(mk(5, 3'd5, 0));
        segs.push_back(mk(0, 3'd3, 0)); segs.push_back(mk(11, 3'd4, 0));
        segs.push_back(mk(5, 3'd5, 0)); segs.push_back(mk(16, 3'd6, 0));
        segs.push_back(fin());
        // run 4: KICK5 from 11 in RISE3
        segs.push_back(mk(6, 3'd2, 0)); segs.push_back(mk(0, 3'd3, 0));
        segs.push_back(mk(11, 3'd4, 0)); segs.push_back(mk(5, 3'd5, 0));
        segs.push_back(mk(11, 3'd6, 0)); segs.push_back(mk(5, 3'd7, 0));
        segs.push_back(mk(16, 3'd6, 0)); segs.push_back(fin());

        #2;
        check("reset_outs",
              {3'd0, level, phase, fall3, cycle_done, err_pulse, err_code,
               cycle_cnt, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        back_to_idle();

        foreach (segs[i]) begin
            ramp(segs[i]);
            if (segs[i].done) begin
                idle(3);
                check("cycle_cnt_run", {24'd0, cycle_cnt}, exp_cycles);
                check("err_cnt_run", {24'd0, err_cnt}, exp_errs);
            end
        end

        // malformed pattern in RISE1, then recovery and a clean run
        ramp(mk(3, 3'd2, 0));
        err_step(16'h0005, 3, 2'b01);
        back_to_idle();
        for (int i = 0; i < 6; i++) ramp(segs[i]);
        idle(3);
        check("cycle_cnt_recover", {24'd0, cycle_cnt}, exp_cycles);

        // hold, jump and reversal errors
        ramp(mk(3, 3'd2, 0));
        err_step(thermo(3), 3, 2'b10);
        back_to_idle();
        ramp(mk(4, 3'd2, 0));
        err_step(thermo(6), 6, 2'b10);
        back_to_idle();
        ramp(mk(6, 3'd2, 0)); ramp(mk(0, 3'd3, 0)); ramp(mk(8, 3'd4, 0));
        err_step(thermo(7), 7, 2'b11);
        back_to_idle();
        idle(3);
        check("err_cnt_steps", {24'd0, err_cnt}, exp_errs);

        // asynchronous reset mid-RISE3
        ramp(mk(6, 3'd2, 0)); ramp(mk(0, 3'd3, 0)); ramp(mk(11, 3'd4, 0));
        ramp(mk(5, 3'd5, 0)); ramp(mk(10, 3'd6, 0));
        idle(2);
        check("pre_reset_phase", {29'd0, phase}, 32'd6);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset",
              {3'd0, level, phase, fall3, cycle_done, err_pulse, err_code,
               cycle_cnt, err_cnt}, 32'd0);
        q.delete();
        cur_lvl = 0; cur_code = 2'b00; exp_cycles = 0; exp_errs = 0;
        led = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("release_idle", {29'd0, phase}, 32'd1);

        // error counter saturation
        repeat (300) begin
            @(negedge clk); led = thermo(2);
            @(negedge clk); led = 16'h0000;
        end
        idle(4);
        check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
        check("err_code_sat", {30'd0, err_code}, 32'd2);
        check("phase_sat", {29'd0, phase}, 32'd1);

        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
